// File: rtl/fir_stream_pkg.sv
// rtl/fir_stream_pkg.sv - shared types and defaults for the ECG sample streamer
package fir_stream_pkg;

    localparam int DEFAULT_FILTER_TAPS = 17;
    localparam int DEFAULT_DATA_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_DONE   = 2'd3
    } stream_state_t;

endpackage

// File: rtl/rate_tick_gen.sv
// rtl/rate_tick_gen.sv - loadable down-counter producing one tick every period+1 clocks
module rate_tick_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [DIV_W-1:0] period,
    output logic             tick
);

    logic [DIV_W-1:0] r_cnt;

    assign tick = (r_cnt == '0);

    // Loading to zero makes the first tick land on the cycle right after load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= period;
        end else begin
            r_cnt <= r_cnt - DIV_W'(1);
        end
    end

endmodule

// File: rtl/ecg_sample_streamer.sv
// rtl/ecg_sample_streamer.sv - plays a stored ECG record into the FIR filter, then flushes it with zeros
module ecg_sample_streamer
    import fir_stream_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int ADDR_W      = 10,
    parameter int FILTER_TAPS = DEFAULT_FILTER_TAPS,
    parameter int DIV_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   num_samples,
    input  logic [DIV_W-1:0]  rate_div,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W+5:0] sample_count
);

    localparam int CNT_W = ADDR_W + 6;
    localparam logic [CNT_W-1:0] FLUSH_LEN = CNT_W'(FILTER_TAPS - 1);

    stream_state_t     r_state;
    stream_state_t     w_next_state;
    logic [ADDR_W:0]   r_num;
    logic [DIV_W-1:0]  r_rate_div;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_sample;
    logic              r_valid;
    logic              r_done;
    logic              w_tick;
    logic              w_load;
    logic [CNT_W-1:0]  w_count_inc;
    logic [CNT_W-1:0]  w_num_ext;
    logic [CNT_W-1:0]  w_total;

    assign w_load      = (r_state == ST_IDLE) && start;
    assign w_count_inc = r_count + CNT_W'(1);
    assign w_num_ext   = CNT_W'(r_num);
    assign w_total     = w_num_ext + FLUSH_LEN;

    rate_tick_gen #(
        .DIV_W (DIV_W)
    ) u_rate_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .load   (w_load),
        .period (r_rate_div),
        .tick   (w_tick)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = (num_samples != '0) ? ST_STREAM : ST_FLUSH;
                end
            end
            ST_STREAM: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (w_tick && (w_count_inc == w_num_ext)) begin
                    w_next_state = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (w_tick && (w_count_inc == w_total)) begin
                    w_next_state = ST_DONE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // done trails the DONE state by one edge so it coincides with busy falling.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_num      <= '0;
            r_rate_div <= '0;
            r_addr     <= '0;
            r_count    <= '0;
            r_sample   <= '0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_valid <= 1'b0;
            r_done  <= (r_state == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_num      <= num_samples;
                        r_rate_div <= rate_div;
                        r_count    <= '0;
                        r_addr     <= '0;
                    end
                end
                ST_STREAM: begin
                    if (abort) begin
                        r_sample <= '0;
                    end else if (w_tick) begin
                        r_sample <= mem_rdata;
                        r_valid  <= 1'b1;
                        r_count  <= w_count_inc;
                        r_addr   <= r_addr + ADDR_W'(1);
                    end
                end
                ST_FLUSH: begin
                    if (abort) begin
                        r_sample <= '0;
                    end else if (w_tick) begin
                        r_sample <= '0;
                        r_valid  <= 1'b1;
                        r_count  <= w_count_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_addr     = r_addr;
    assign sample_out   = r_sample;
    assign sample_valid = r_valid;
    assign busy         = (r_state != ST_IDLE);
    assign done         = r_done;
    assign sample_count = r_count;

endmodule
